wb_sequencer: RTL and testbench

- Sequences the write-back stage: accepts one retiring instruction per cycle from MEM and selects ALU result or load data for the register file.
- Holds the pipeline while a multi-cycle load returns, then issues a single registered register-file write.
- Sits between the MEM/WB boundary and the register-file write port, and drives the write-back data-select mux.

---
 rtl/wb_pkg.sv | 30 +++
 rtl/wb_timeout_ctr.sv | 44 ++++
 rtl/wb_sequencer.sv | 118 +++++++++++
 tb/tb_wb_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg -- shared definitions for the write-back sequencer.
//
// Contents:
//   state_t       : sequencer FSM states (IDLE, WAIT_MEM)
//   DATA_W_DEF    : default data / address width
//   REG_AW_DEF    : default register index width
//   TIMEOUT_DEF   : default load-timeout in cycles
//   ZERO_REG      : architectural hard-wired zero register index
//   is_zero_reg() : true when a destination index names the zero register
// ---------------------------------------------------------------------------
package wb_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  localparam int DATA_W_DEF  = 32;
  localparam int REG_AW_DEF  = 5;
  localparam int TIMEOUT_DEF = 16;
  localparam int ZERO_REG    = 0;

  // Writes to the zero register are architecturally discarded. The index is
  // passed as a 32-bit value so the helper works for any REG_AW up to 32.
  function automatic logic is_zero_reg(input logic [31:0] idx);
    return idx == 32'(ZERO_REG);
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// ---------------------------------------------------------------------------
// wb_timeout_ctr -- clearable cycle counter with terminal-count flag.
//
// Counts cycles spent waiting for load data. The count is cleared on the
// cycle a load is accepted, so the first waiting cycle sees count 0 and the
// TIMEOUT-th waiting cycle sees count TIMEOUT-1 (terminal asserted).
//
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  asynchronous active-high reset (count -> 0)
//   clear    in  synchronous clear, has priority over enable
//   enable   in  increment count this cycle
//   terminal out high while count == TIMEOUT-1
// ---------------------------------------------------------------------------
module wb_timeout_ctr #(
  parameter int TIMEOUT = 16,
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      // Terminal count always causes the owner to leave the waiting state,
      // so wrap-around is never observed in practice; saturate anyway.
      if (!terminal) begin
        count <= count + CW'(1);
      end
    end
  end

  assign terminal = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_sequencer.sv
// ---------------------------------------------------------------------------
// wb_sequencer -- write-back stage sequencer.
//
// Accepts one retiring instruction per cycle from MEM. ALU results are
// written to the register file one cycle after acceptance. Loads freeze the
// pipeline in WAIT_MEM until mem_rvalid returns (or the timeout expires),
// then issue a single registered register-file write of the load data.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   in_valid        retiring instruction present
//   in_ready        sequencer can accept (transfer = in_valid & in_ready)
//   in_reg_write    instruction writes a register
//   in_mem_to_reg   1 = load data, 0 = ALU result (in_addr)
//   in_dest         destination register index
//   in_addr         ALU result / effective address
//   mem_rdata       load data
//   mem_rvalid      mem_rdata valid this cycle (only observed in WAIT_MEM)
//   rf_we           register-file write enable, single-cycle pulse
//   rf_waddr        register-file write index (held while rf_we=0)
//   rf_wdata        register-file write data  (held while rf_we=0)
//   stall           freeze upstream stages (= ~in_ready)
//   timeout_err     sticky load-timeout flag, cleared only by rst
// ---------------------------------------------------------------------------
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [REG_AW-1:0] in_dest,
  input  logic [DATA_W-1:0] in_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall,
  output logic              timeout_err
);

  state_t            state;
  logic [REG_AW-1:0] load_dest;
  logic              transfer;
  logic              start_load;
  logic              timeout_hit;

  // in_ready is a pure decode of the state register, so it is glitch-free
  // and already 1 while reset holds the FSM in IDLE.
  assign in_ready   = (state == IDLE);
  assign stall      = ~in_ready;
  assign transfer   = in_valid & in_ready;
  assign start_load = transfer & in_reg_write & in_mem_to_reg;

  wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_load),
    .enable   (state == WAIT_MEM),
    .terminal (timeout_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      load_dest   <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      timeout_err <= 1'b0;
    end else begin
      // Write enable is a one-cycle pulse; address/data hold otherwise.
      rf_we <= 1'b0;

      case (state)
        IDLE: begin
          if (transfer && in_reg_write) begin
            if (in_mem_to_reg) begin
              load_dest <= in_dest;
              state     <= WAIT_MEM;
            end else if (!is_zero_reg(32'(in_dest))) begin
              rf_we    <= 1'b1;
              rf_waddr <= in_dest;
              rf_wdata <= in_addr;
            end
          end
        end

        WAIT_MEM: begin
          // Returning data takes priority over a simultaneous timeout.
          if (mem_rvalid) begin
            state <= IDLE;
            if (!is_zero_reg(32'(load_dest))) begin
              rf_we    <= 1'b1;
              rf_waddr <= load_dest;
              rf_wdata <= mem_rdata;
            end
          end else if (timeout_hit) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wb_sequencer -- directed self-checking bench for wb_sequencer.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so they reflect the state updated by that edge.
// ---------------------------------------------------------------------------
module tb_wb_sequencer;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int TIMEOUT = 16;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_reg_write;
  logic              in_mem_to_reg;
  logic [REG_AW-1:0] in_dest;
  logic [DATA_W-1:0] in_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              stall;
  logic              timeout_err;

  int checks;
  int errors;

  wb_sequencer #(
    .DATA_W  (DATA_W),
    .REG_AW  (REG_AW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg_write  (in_reg_write),
    .in_mem_to_reg (in_mem_to_reg),
    .in_dest       (in_dest),
    .in_addr       (in_addr),
    .mem_rdata     (mem_rdata),
    .mem_rvalid    (mem_rvalid),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .stall         (stall),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid      = 1'b0;
    in_reg_write  = 1'b0;
    in_mem_to_reg = 1'b0;
    in_dest       = '0;
    in_addr       = '0;
  endtask

  task automatic drive_op(input logic rw, input logic m2r,
                          input logic [REG_AW-1:0] dest, input logic [DATA_W-1:0] addr);
    in_valid      = 1'b1;
    in_reg_write  = rw;
    in_mem_to_reg = m2r;
    in_dest       = dest;
    in_addr       = addr;
    $display("txn  t=%0t rw=%0b m2r=%0b dest=%0d addr=%08h", $time, rw, m2r, dest, addr);
  endtask

  initial begin
    int stall_cnt;
    int we_cnt;

    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    drive_idle();

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("rst_we",     64'(rf_we),       64'd0);
    check("rst_waddr",  64'(rf_waddr),    64'd0);
    check("rst_wdata",  64'(rf_wdata),    64'd0);
    check("rst_terr",   64'(timeout_err), 64'd0);
    check("rst_ready",  64'(in_ready),    64'd1);
    check("rst_stall",  64'(stall),       64'd0);
    rst = 1'b0;
    tick();

    // ---------------- ALU writeback ----------------
    drive_op(1'b1, 1'b0, 5'd5, 32'h8badf00d);
    check("alu_stall0", 64'(stall), 64'd0);
    tick();
    drive_idle();
    check("alu_we",    64'(rf_we),    64'd1);
    check("alu_waddr", 64'(rf_waddr), 64'd5);
    check("alu_wdata", 64'(rf_wdata), 64'h8badf00d);
    check("alu_stall1", 64'(stall),   64'd0);
    tick();
    check("alu_we_pulse", 64'(rf_we),    64'd0);
    check("alu_hold_a",   64'(rf_waddr), 64'd5);
    check("alu_hold_d",   64'(rf_wdata), 64'h8badf00d);

    // ---------------- load, 3-cycle latency ----------------
    drive_op(1'b1, 1'b1, 5'd9, 32'h00001000);
    tick();
    // Waiting cycle 1: junk on in_* must be ignored while stalled.
    drive_op(1'b1, 1'b0, 5'd7, 32'h11111111);
    check("ld_stall1", 64'(stall), 64'd1);
    check("ld_we1",    64'(rf_we), 64'd0);
    tick();
    check("ld_stall2", 64'(stall), 64'd1);
    drive_idle();
    tick();
    check("ld_stall3", 64'(stall), 64'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hdeadbeef;
    tick();
    mem_rvalid = 1'b0;
    check("ld_we",    64'(rf_we),    64'd1);
    check("ld_waddr", 64'(rf_waddr), 64'd9);
    check("ld_wdata", 64'(rf_wdata), 64'hdeadbeef);
    check("ld_ready", 64'(in_ready), 64'd1);
    tick();
    check("ld_junk_ignored", 64'(rf_we), 64'd0);

    // ---------------- back-to-back ALU ops, then $0 ----------------
    for (int i = 1; i <= 3; i++) begin
      drive_op(1'b1, 1'b0, REG_AW'(i), 32'hA0000000 + DATA_W'(i));
      tick();
      check($sformatf("b2b_we%0d", i),    64'(rf_we),    64'd1);
      check($sformatf("b2b_waddr%0d", i), 64'(rf_waddr), 64'(i));
      check($sformatf("b2b_wdata%0d", i), 64'(rf_wdata), 64'hA0000000 + 64'(i));
    end
    drive_op(1'b1, 1'b0, 5'd0, 32'h55555555);
    tick();
    drive_idle();
    check("zero_we",    64'(rf_we),    64'd0);
    check("zero_waddr", 64'(rf_waddr), 64'd3);
    check("zero_wdata", 64'(rf_wdata), 64'hA0000003);

    // reg_write=0 produces nothing
    drive_op(1'b0, 1'b0, 5'd8, 32'h12345678);
    tick();
    drive_idle();
    check("nowr_we",    64'(rf_we), 64'd0);
    check("nowr_stall", 64'(stall), 64'd0);

    // ---------------- rvalid on terminal cycle ----------------
    drive_op(1'b1, 1'b1, 5'd4, 32'h0);
    tick();
    drive_idle();
    for (int k = 1; k < TIMEOUT; k++) tick();
    check("term_stall16", 64'(stall), 64'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hcafef00d;
    tick();
    mem_rvalid = 1'b0;
    check("term_we",    64'(rf_we),       64'd1);
    check("term_waddr", 64'(rf_waddr),    64'd4);
    check("term_wdata", 64'(rf_wdata),    64'hcafef00d);
    check("term_terr",  64'(timeout_err), 64'd0);
    check("term_ready", 64'(in_ready),    64'd1);

    // ---------------- load to $0 still waits ----------------
    drive_op(1'b1, 1'b1, 5'd0, 32'h0);
    tick();
    drive_idle();
    check("z0_stall", 64'(stall), 64'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h77777777;
    tick();
    mem_rvalid = 1'b0;
    check("z0_we",    64'(rf_we), 64'd0);
    check("z0_stall_done", 64'(stall), 64'd0);

    // ---------------- timeout ----------------
    drive_op(1'b1, 1'b1, 5'd12, 32'h0);
    tick();
    drive_idle();
    stall_cnt = 0;
    we_cnt    = 0;
    // Bounded: a stuck FSM simply shows up as a wrong stall count.
    for (int k = 0; k < TIMEOUT + 4; k++) begin
      if (stall) stall_cnt++;
      if (rf_we) we_cnt++;
      tick();
    end
    check("to_stall_cycles", 64'(stall_cnt),   64'(TIMEOUT));
    check("to_no_we",        64'(we_cnt),      64'd0);
    check("to_terr",         64'(timeout_err), 64'd1);
    check("to_ready",        64'(in_ready),    64'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h99999999;
    tick();
    mem_rvalid = 1'b0;
    check("to_late_rvalid_we", 64'(rf_we),       64'd0);
    check("to_terr_sticky",    64'(timeout_err), 64'd1);

    // ---------------- reset mid-WAIT_MEM ----------------
    drive_op(1'b1, 1'b1, 5'd6, 32'h0);
    tick();
    drive_idle();
    tick();
    rst = 1'b1;
    #1;
    check("mrst_we",    64'(rf_we),       64'd0);
    check("mrst_waddr", 64'(rf_waddr),    64'd0);
    check("mrst_wdata", 64'(rf_wdata),    64'd0);
    check("mrst_terr",  64'(timeout_err), 64'd0);
    check("mrst_ready", 64'(in_ready),    64'd1);
    check("mrst_stall", 64'(stall),       64'd0);
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h44444444;
    tick();
    mem_rvalid = 1'b0;
    check("mrst_late_we", 64'(rf_we), 64'd0);
    tick();
    check("mrst_late_we2", 64'(rf_we), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
